// File: rtl/led_colour_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_colour_driver
// Brief    : Decodes a 3-bit RGB colour code into per-channel PWM drive at a
//            programmable brightness. Updates take effect only at PWM period
//            boundaries. Optional macro LED_FADE_EN ramps brightness 1 LSB/period.
// Revision : 1.0 - initial release
// ============================================================================
module led_colour_driver #(
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       colour,
  input  logic [PWM_W-1:0] duty,
  input  logic             err_clr,
  output logic [2:0]       rgb,
  output logic             upd,
  output logic             err
);

  localparam int              PS_W    = $clog2(PRESCALE) + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]  presc;
  logic [PWM_W-1:0] cnt;
  logic [2:0]       colour_q;
  logic [PWM_W-1:0] duty_q;

  logic tick;
  logic bnd;
  logic colour_bad;
  logic on;

  assign tick       = (presc == PS_LAST);
  assign bnd        = tick && (cnt == CNT_MAX);
  assign colour_bad = (colour == 3'b000) || (colour == 3'b111);
  assign on         = (duty_q == CNT_MAX) || (cnt < duty_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + PWM_W'(1);
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // Colour, brightness and the change pulse are all decided at the boundary only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= 3'b001;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (bnd && !colour_bad) begin
        colour_q <= colour;
        upd      <= (colour != colour_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (bnd) begin
`ifdef LED_FADE_EN
      if (duty > duty_q) begin
        duty_q <= duty_q + PWM_W'(1);
      end else if (duty < duty_q) begin
        duty_q <= duty_q - PWM_W'(1);
      end
`else
      duty_q <= duty;
`endif
    end
  end

  // A new invalid code wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (bnd && colour_bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= 3'b000;
    end else begin
      rgb <= colour_q & {3{on}};
    end
  end

endmodule
`default_nettype wire
